// File: rtl/io_panel.sv
// io_panel: debounced front-panel buttons feeding a one-deep press event queue,
// plus a time-multiplexed active-low seven-segment scan. Define BTN_REPEAT_EN for key auto-repeat.
module io_panel #(
    parameter int DIGITS   = 4,
    parameter int BTNS     = 5,
    parameter int DIV_LOG2 = 16,
    parameter int DEB_N    = 4,
    parameter int CW       = 4
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic [BTNS-1:0]       btn,
    input  logic [4*DIGITS-1:0]   disp_val,
    input  logic [DIGITS-1:0]     disp_dp,
    input  logic [DIGITS-1:0]     disp_blank,
    output logic [BTNS-1:0]       btn_level,
    output logic [BTNS-1:0]       btn_press,
    output logic                  evt_valid,
    output logic [CW-1:0]         evt_code,
    input  logic                  evt_ack,
    output logic                  evt_ovf,
    output logic [DIGITS+7:0]     seg
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_LOG2-1:0] pre_cnt;
    logic                tick;
    logic [IW-1:0]       digit_idx;
    logic [BTNS-1:0]     sync1, sync2, level_d, rep_fire, press_raw;
    logic [3:0]          deb_cnt [BTNS];

    assign tick = &pre_cnt;

    always_ff @(posedge mclk) begin
        if (rst) begin
            pre_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            pre_cnt <= pre_cnt + DIV_LOG2'(1);
            if (tick)
                digit_idx <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + IW'(1);
        end
    end

    // A new level is accepted only after DEB_N consecutive differing tick samples.
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_level <= '0;
            for (int i = 0; i < BTNS; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (tick) begin
                for (int i = 0; i < BTNS; i++) begin
                    if (sync2[i] == btn_level[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == 4'(DEB_N - 1)) begin
                        btn_level[i] <= sync2[i];
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int REP_DELAY = 32;
    localparam int REP_RATE  = 8;

    logic [5:0]      rep_cnt [BTNS];
    logic [BTNS-1:0] rep_phase;

    // Counts held ticks; registered fire keeps repeat-to-press latency equal to the original press.
    always_ff @(posedge mclk) begin
        if (rst) begin
            rep_fire  <= '0;
            rep_phase <= '0;
            for (int i = 0; i < BTNS; i++) rep_cnt[i] <= '0;
        end else begin
            rep_fire <= '0;
            for (int i = 0; i < BTNS; i++) begin
                if (!btn_level[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (tick) begin
                    if (rep_cnt[i] == (rep_phase[i] ? 6'(REP_RATE - 1) : 6'(REP_DELAY - 1))) begin
                        rep_cnt[i]   <= '0;
                        rep_phase[i] <= 1'b1;
                        rep_fire[i]  <= 1'b1;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + 6'd1;
                    end
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign press_raw = (btn_level & ~level_d) | rep_fire;

    always_ff @(posedge mclk) begin
        if (rst) begin
            level_d   <= '0;
            btn_press <= '0;
        end else begin
            level_d   <= btn_level;
            btn_press <= press_raw;
        end
    end

    function automatic logic [CW-1:0] lowest_idx(input logic [BTNS-1:0] v);
        lowest_idx = '0;
        for (int i = BTNS - 1; i >= 0; i--)
            if (v[i]) lowest_idx = CW'(i);
    endfunction

    // Only the lowest simultaneous press is kept; anything else that cannot be queued is an overflow.
    always_ff @(posedge mclk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_ovf   <= 1'b0;
        end else if (|btn_press) begin
            if (!evt_valid || evt_ack) begin
                evt_valid <= 1'b1;
                evt_code  <= lowest_idx(btn_press);
                if ((btn_press & (btn_press - BTNS'(1))) != '0)
                    evt_ovf <= 1'b1;
            end else begin
                evt_ovf <= 1'b1;
            end
        end else if (evt_ack) begin
            evt_valid <= 1'b0;
        end
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge mclk) begin
        if (rst || disp_blank[digit_idx])
            seg <= '1;
        else
            seg <= {~(DIGITS'(1) << digit_idx), ~disp_dp[digit_idx],
                    hex_seg(disp_val[int'(digit_idx) * 4 +: 4])};
    end
endmodule

// File: tb/tb_io_panel.sv
// tb_io_panel: randomized button/display stimulus with queued expected events and
// per-cycle expected segment words, checked by an independent negedge monitor.
module tb_io_panel;
    localparam int DIGITS = 4;
    localparam int BTNS   = 5;
    localparam int CW     = 4;

    logic              mclk = 1'b0;
    logic              rst;
    logic [BTNS-1:0]   btn;
    logic [15:0]       disp_val;
    logic [3:0]        disp_dp, disp_blank;
    logic [BTNS-1:0]   btn_level, btn_press;
    logic              evt_valid, evt_ack, evt_ovf;
    logic [CW-1:0]     evt_code;
    logic [11:0]       seg;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic auto_ack = 1'b0, manual_ack = 1'b0, disp_rand = 1'b0;
    int   exp_q[$];
    logic [11:0] seg_q[$];
    int   press_cnt [BTNS];
    int   exp_press [BTNS];
    int   press0_times[$];
    logic exp_ovf = 1'b0;
    logic valid_q = 1'b0, ack_q = 1'b0;

    // Lit segments per hex digit, bit 0 = a ... bit 6 = g, 1 = lit.
    logic [6:0] seg_lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 mclk = ~mclk;

    io_panel #(.DIGITS(DIGITS), .BTNS(BTNS), .DIV_LOG2(2), .DEB_N(3), .CW(CW)) dut (
        .mclk(mclk), .rst(rst), .btn(btn),
        .disp_val(disp_val), .disp_dp(disp_dp), .disp_blank(disp_blank),
        .btn_level(btn_level), .btn_press(btn_press),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ack(evt_ack),
        .evt_ovf(evt_ovf), .seg(seg)
    );

    always @(posedge mclk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] segModel(input int idx, input logic [15:0] v,
                                             input logic [3:0] dp, input logic [3:0] bl);
        logic [3:0] one_hot;
        logic [3:0] nib;
        if (bl[idx]) return 12'hFFF;
        one_hot = 4'b0001 << idx;
        nib = v[idx*4 +: 4];
        return {~one_hot, ~dp[idx], ~seg_lit[nib]};
    endfunction

    function automatic int lowestBit(input logic [BTNS-1:0] m);
        for (int i = 0; i < BTNS; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge mclk);
        #2;
    endtask

    // Consumer ack and display input driver, updated just after each rising edge.
    initial begin
        evt_ack = 1'b0;
        forever begin
            @(posedge mclk);
            #1;
            evt_ack = auto_ack ? (evt_valid && ($urandom_range(0, 2) == 0)) : manual_ack;
            if (disp_rand && ($urandom_range(0, 7) == 0)) begin
                disp_val   = 16'($urandom);
                disp_dp    = 4'($urandom);
                disp_blank = 4'($urandom);
            end
        end
    end

    // Monitor: seg checked every cycle one edge after its inputs; events checked on acceptance.
    initial begin
        logic [11:0] s;
        for (int i = 0; i < BTNS; i++) press_cnt[i] = 0;
        forever begin
            @(negedge mclk);
            if (seg_q.size() > 0) begin
                s = seg_q.pop_front();
                checkOutput("seg", 32'(seg), 32'(s));
            end
            seg_q.push_back(rst ? 12'hFFF : segModel((cyc / 4) % 4, disp_val, disp_dp, disp_blank));
            if (rst) begin
                valid_q = 1'b0;
                ack_q   = 1'b0;
            end else begin
                if (evt_valid && (!valid_q || ack_q)) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL evt_unexpected: got code %0d, required no event", evt_code);
                    end else begin
                        checkOutput("evt_code", 32'(evt_code), 32'(exp_q.pop_front()));
                    end
                end
                valid_q = evt_valid;
                ack_q   = evt_ack;
                for (int i = 0; i < BTNS; i++)
                    if (btn_press[i]) begin
                        press_cnt[i]++;
                        if (i == 0) press0_times.push_back(cyc);
                    end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [BTNS-1:0] mask, input int hold, input int rel);
        btn = mask;
        waitCycles(hold);
        checkOutput("btn_level_held", 32'(btn_level), 32'(mask));
        btn = '0;
        waitCycles(rel);
        checkOutput("btn_level_released", 32'(btn_level), 32'(0));
    endtask

    task automatic pressExpected(input logic [BTNS-1:0] mask, input bit queued);
        if (queued) exp_q.push_back(lowestBit(mask));
        if ($countones(mask) > 1) exp_ovf = 1'b1;
        for (int i = 0; i < BTNS; i++)
            if (mask[i]) exp_press[i]++;
    endtask

    task automatic drainEvents();
        int n = 0;
        while ((exp_q.size() > 0 || evt_valid) && n < 400) begin
            waitCycles(1);
            n++;
        end
        checkOutput("evt_drain_pending", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic checkPresses();
        for (int i = 0; i < BTNS; i++)
            checkOutput($sformatf("press_count[%0d]", i), 32'(press_cnt[i]), 32'(exp_press[i]));
    endtask

    initial begin
        for (int i = 0; i < BTNS; i++) exp_press[i] = 0;
        rst = 1'b1;
        btn = '1;
        disp_val = 16'h1F80;
        disp_dp = 4'b0100;
        disp_blank = 4'b0001;

        repeat (3) begin
            @(negedge mclk);
            checkOutput("reset_seg", 32'(seg), 32'hFFF);
            checkOutput("reset_level", 32'(btn_level), 32'(0));
            checkOutput("reset_valid", 32'(evt_valid), 32'(0));
            checkOutput("reset_ovf", 32'(evt_ovf), 32'(0));
        end
        @(posedge mclk);
        #2;
        rst = 1'b0;
        btn = '0;
        waitCycles(1);
        checkOutput("post_reset_level", 32'(btn_level), 32'(0));
        checkOutput("post_reset_valid", 32'(evt_valid), 32'(0));
        checkOutput("post_reset_ovf", 32'(evt_ovf), 32'(0));

        // Fixed display pattern is scanned several times before anything else moves.
        waitCycles(40);
        auto_ack = 1'b1;

        pressExpected(5'b01010, 1'b1);
        applyStimulus(5'b01010, 40, 40);
        drainEvents();
        checkOutput("simultaneous_ovf", 32'(evt_ovf), 32'(1));
        checkPresses();

        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        exp_ovf = 1'b0;
        waitCycles(1);
        checkOutput("ovf_cleared_by_reset", 32'(evt_ovf), 32'(0));

        btn = 5'b01000;
        waitCycles(6);
        rst = 1'b1;
        btn = '0;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(40);
        checkOutput("half_debounce_level", 32'(btn_level), 32'(0));
        checkPresses();

        btn = 5'b00100;
        waitCycles(4);
        btn = '0;
        waitCycles(30);
        checkOutput("glitch_level", 32'(btn_level), 32'(0));
        checkPresses();

        auto_ack = 1'b0;
        pressExpected(5'b00100, 1'b1);
        applyStimulus(5'b00100, 40, 40);
        checkOutput("pending_valid", 32'(evt_valid), 32'(1));
        checkOutput("pending_code", 32'(evt_code), 32'(2));

        pressExpected(5'b00001, 1'b0);
        exp_ovf = 1'b1;
        applyStimulus(5'b00001, 40, 40);
        checkOutput("drop_ovf", 32'(evt_ovf), 32'(exp_ovf));
        checkOutput("drop_code_holds", 32'(evt_code), 32'(2));
        checkOutput("drop_valid_holds", 32'(evt_valid), 32'(1));

        manual_ack = 1'b1;
        waitCycles(1);
        manual_ack = 1'b0;
        waitCycles(1);
        checkOutput("ack_clears_valid", 32'(evt_valid), 32'(0));
        checkOutput("ack_code_holds", 32'(evt_code), 32'(2));

        pressExpected(5'b10000, 1'b1);
        applyStimulus(5'b10000, 40, 40);
        checkOutput("new_event_code", 32'(evt_code), 32'(4));
        auto_ack = 1'b1;
        drainEvents();
        checkPresses();

        disp_rand = 1'b1;
        for (int it = 0; it < 30; it++) begin
            logic [BTNS-1:0] m;
            if ($urandom_range(0, 4) == 0) begin
                btn = BTNS'(1) << $urandom_range(0, BTNS - 1);
                waitCycles($urandom_range(1, 4));
                btn = '0;
                waitCycles(30);
                checkOutput("rand_glitch_level", 32'(btn_level), 32'(0));
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    m = BTNS'($urandom);
                    if (m == '0) m = 5'b00011;
                end else begin
                    m = BTNS'(1) << $urandom_range(0, BTNS - 1);
                end
                pressExpected(m, 1'b1);
                applyStimulus(m, $urandom_range(24, 60), $urandom_range(24, 60));
                drainEvents();
                checkOutput("rand_ovf", 32'(evt_ovf), 32'(exp_ovf));
            end
        end
        checkPresses();

        begin
            int n_before;
            int n_exp;
`ifdef BTN_REPEAT_EN
            n_exp = 5;
`else
            n_exp = 1;
`endif
            n_before = press0_times.size();
            for (int k = 0; k < n_exp; k++) begin
                exp_q.push_back(0);
                exp_press[0]++;
            end
            applyStimulus(5'b00001, 240, 60);
            drainEvents();
            checkOutput("hold_press_count", 32'(press0_times.size() - n_before), 32'(n_exp));
`ifdef BTN_REPEAT_EN
            if (press0_times.size() - n_before == 5) begin
                checkOutput("repeat_delay", 32'(press0_times[n_before+1] - press0_times[n_before]), 32'(128));
                for (int k = 2; k < 5; k++)
                    checkOutput("repeat_rate", 32'(press0_times[n_before+k] - press0_times[n_before+k-1]), 32'(32));
            end
`endif
        end
        checkPresses();
        checkOutput("final_ovf", 32'(evt_ovf), 32'(exp_ovf));

        waitCycles(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
